sgmii_enc8b10b: RTL and testbench

- Registered 8b/10b encoder sitting directly downstream of the PCS transmit ordered-set state machine.
- Accepts one code group per clock as an octet plus a control (K) flag and produces the 10-bit transmission character for the SERDES.
- Maintains the running disparity and exports it back to the transmit state machine, which uses it to choose the IDLE data character (/D5.6/ or /D16.2/).
- Flags and counts illegal K requests.

---
 rtl/sgmii_enc8b10b.sv | 227 ++++++++++++++++++++++
 tb/tb_sgmii_enc8b10b.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgmii_enc8b10b.sv
// 8b/10b encoder for the SGMII/1000BASE-X PCS transmit path; one code group per clock.
// Latency: one clock from i_Valid to o10_Code/o_CodeValid; running disparity updates at the same edge.
// No back-pressure: every valid group is encoded; illegal K requests become K30.7 and are counted.
module sgmii_enc8b10b #(
  parameter logic pInitRD = 1'b1  // 1 = RD-, 0 = RD+
) (
  input  logic       i_Clk,
  input  logic       i_ARst,
  input  logic [7:0] i8_Data,
  input  logic       i_Ctrl,
  input  logic       i_Valid,
  output logic [9:0] o10_Code,
  output logic       o_CodeValid,
  output logic       o_CurrentParity,
  output logic       o_KErr,
  output logic       o_Comma,
  output logic [7:0] o8_KErrCnt
);

  // Running disparity is carried as an "RD-" flag throughout: 1 = RD-, 0 = RD+.

  // 5b/6b data table, RD- column (abcdei). The RD+ column is the complement
  // wherever this entry is unbalanced or is the D7 special 111000.
  function automatic logic [5:0] six_rdm(input logic [4:0] x);
    logic [5:0] r;
    case (x)
      5'd0:  r = 6'b100111;
      5'd1:  r = 6'b011101;
      5'd2:  r = 6'b101101;
      5'd3:  r = 6'b110001;
      5'd4:  r = 6'b110101;
      5'd5:  r = 6'b101001;
      5'd6:  r = 6'b011001;
      5'd7:  r = 6'b111000;
      5'd8:  r = 6'b111001;
      5'd9:  r = 6'b100101;
      5'd10: r = 6'b010101;
      5'd11: r = 6'b110100;
      5'd12: r = 6'b001101;
      5'd13: r = 6'b101100;
      5'd14: r = 6'b011100;
      5'd15: r = 6'b010111;
      5'd16: r = 6'b011011;
      5'd17: r = 6'b100011;
      5'd18: r = 6'b010011;
      5'd19: r = 6'b110010;
      5'd20: r = 6'b001011;
      5'd21: r = 6'b101010;
      5'd22: r = 6'b011010;
      5'd23: r = 6'b111010;
      5'd24: r = 6'b110011;
      5'd25: r = 6'b100110;
      5'd26: r = 6'b010110;
      5'd27: r = 6'b110110;
      5'd28: r = 6'b001110;
      5'd29: r = 6'b101110;
      5'd30: r = 6'b011110;
      default: r = 6'b101011;  // D31
    endcase
    return r;
  endfunction

  // 3b/4b data table, RD- column (fghj), with P7 for y = 7. The RD+ column is
  // the complement wherever this entry is unbalanced or is the D.x.3 1100.
  function automatic logic [3:0] four_rdm(input logic [2:0] y);
    logic [3:0] r;
    case (y)
      3'd0: r = 4'b1011;
      3'd1: r = 4'b1001;
      3'd2: r = 4'b0101;
      3'd3: r = 4'b1100;
      3'd4: r = 4'b1101;
      3'd5: r = 4'b1010;
      3'd6: r = 4'b0110;
      default: r = 4'b1110;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] ones6(input logic [5:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} +
           {2'b00, v[3]} + {2'b00, v[4]} + {2'b00, v[5]};
  endfunction

  function automatic logic [2:0] ones4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // RD after a 6b sub-block; 000111 and 111000 count as unbalanced towards their tail.
  function automatic logic next_rd6(input logic rd_in, input logic [5:0] v);
    logic [2:0] n;
    logic       r;
    n = ones6(v);
    if (n > 3'd3)              r = 1'b0;
    else if (n < 3'd3)         r = 1'b1;
    else if (v == 6'b000111)   r = 1'b0;
    else if (v == 6'b111000)   r = 1'b1;
    else                       r = rd_in;
    return r;
  endfunction

  // RD after a 4b sub-block.
  function automatic logic next_rd4(input logic rd_in, input logic [3:0] v);
    logic [2:0] n;
    logic       r;
    n = ones4(v);
    if (n > 3'd2)      r = 1'b0;
    else if (n < 3'd2) r = 1'b1;
    else               r = rd_in;
    return r;
  endfunction

  logic [9:0] code_q,     code_d;
  logic       code_vld_q, code_vld_d;
  logic       rd_q,       rd_d;
  logic       kerr_q,     kerr_d;
  logic       comma_q,    comma_d;
  logic [7:0] kerr_cnt_q, kerr_cnt_d;

  logic [4:0] enc_x;
  logic [2:0] enc_y;
  logic       k_legal;
  logic       k_illegal;
  logic       is_k28;
  logic       use_alt;
  logic       rd_mid;
  logic       rd_end;
  logic [5:0] six_nat;
  logic [5:0] six_enc;
  logic [3:0] four_nat;
  logic [3:0] four_enc;
  logic       comma_grp;

  // Encode the incoming octet against the current running disparity.
  always_comb begin
    enc_x     = i8_Data[4:0];
    enc_y     = i8_Data[7:5];
    k_legal   = (enc_x == 5'd28) ||
                ((enc_y == 3'd7) && ((enc_x == 5'd23) || (enc_x == 5'd27) ||
                                     (enc_x == 5'd29) || (enc_x == 5'd30)));
    k_illegal = i_Ctrl && !k_legal;
    // An illegal K request is replaced by K30.7 so the line still carries a valid character.
    if (k_illegal) begin
      enc_x = 5'd30;
      enc_y = 3'd7;
    end
    is_k28    = i_Ctrl && (enc_x == 5'd28);
    comma_grp = is_k28 && ((enc_y == 3'd1) || (enc_y == 3'd5) || (enc_y == 3'd7));

    six_nat = is_k28 ? 6'b001111 : six_rdm(enc_x);
    if (rd_q || ((ones6(six_nat) == 3'd3) && (six_nat != 6'b111000))) begin
      six_enc = six_nat;
    end else begin
      six_enc = ~six_nat;
    end
    rd_mid = next_rd6(rd_q, six_enc);

    // Alternate 7 avoids a run of five identical bits across the sub-block boundary;
    // K.x.7 always uses it so the comma/control pattern stays distinct.
    use_alt = i_Ctrl ||
              (rd_mid  && ((enc_x == 5'd17) || (enc_x == 5'd18) || (enc_x == 5'd20))) ||
              (!rd_mid && ((enc_x == 5'd11) || (enc_x == 5'd13) || (enc_x == 5'd14)));
    if (enc_y == 3'd7) begin
      four_nat = use_alt ? 4'b0111 : 4'b1110;
    end else begin
      four_nat = four_rdm(enc_y);
    end

    // K28.1/.2/.5/.6 follow the group-start RD so the whole K28 character is
    // exactly complemented between RD- and RD+.
    if (is_k28 && ((enc_y == 3'd1) || (enc_y == 3'd2) || (enc_y == 3'd5) || (enc_y == 3'd6))) begin
      four_enc = rd_q ? four_nat : ~four_nat;
    end else if (rd_mid || ((ones4(four_nat) == 3'd2) && (four_nat != 4'b1100))) begin
      four_enc = four_nat;
    end else begin
      four_enc = ~four_nat;
    end
    rd_end = next_rd4(rd_mid, four_enc);
  end

  // Next-state: load a new group when valid, otherwise hold code/comma/RD and drop the strobes.
  always_comb begin
    code_d     = code_q;
    code_vld_d = 1'b0;
    rd_d       = rd_q;
    kerr_d     = 1'b0;
    comma_d    = comma_q;
    kerr_cnt_d = kerr_cnt_q;
    if (i_Valid) begin
      code_d     = {six_enc, four_enc};
      code_vld_d = 1'b1;
      rd_d       = rd_end;
      kerr_d     = k_illegal;
      comma_d    = comma_grp;
      if (k_illegal && (kerr_cnt_q != 8'hFF)) begin
        kerr_cnt_d = kerr_cnt_q + 8'd1;
      end
    end
  end

  // Output and disparity registers, cleared asynchronously.
  always_ff @(posedge i_Clk or posedge i_ARst) begin
    if (i_ARst) begin
      code_q     <= 10'd0;
      code_vld_q <= 1'b0;
      rd_q       <= pInitRD;
      kerr_q     <= 1'b0;
      comma_q    <= 1'b0;
      kerr_cnt_q <= 8'd0;
    end else begin
      code_q     <= code_d;
      code_vld_q <= code_vld_d;
      rd_q       <= rd_d;
      kerr_q     <= kerr_d;
      comma_q    <= comma_d;
      kerr_cnt_q <= kerr_cnt_d;
    end
  end

  assign o10_Code        = code_q;
  assign o_CodeValid     = code_vld_q;
  assign o_CurrentParity = rd_q;
  assign o_KErr          = kerr_q;
  assign o_Comma         = comma_q;
  assign o8_KErrCnt      = kerr_cnt_q;

endmodule

// File: tb/tb_sgmii_enc8b10b.sv
// Directed and model-checked stimulus for sgmii_enc8b10b.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// The reference model uses independent two-column code tables and popcount-based disparity.
module tb_sgmii_enc8b10b;

  logic       i_Clk;
  logic       i_ARst;
  logic [7:0] i8_Data;
  logic       i_Ctrl;
  logic       i_Valid;
  logic [9:0] o10_Code;
  logic       o_CodeValid;
  logic       o_CurrentParity;
  logic       o_KErr;
  logic       o_Comma;
  logic [7:0] o8_KErrCnt;

  int n_chk = 0;
  int n_err = 0;

  sgmii_enc8b10b #(.pInitRD(1'b1)) dut (
    .i_Clk          (i_Clk),
    .i_ARst         (i_ARst),
    .i8_Data        (i8_Data),
    .i_Ctrl         (i_Ctrl),
    .i_Valid        (i_Valid),
    .o10_Code       (o10_Code),
    .o_CodeValid    (o_CodeValid),
    .o_CurrentParity(o_CurrentParity),
    .o_KErr         (o_KErr),
    .o_Comma        (o_Comma),
    .o8_KErrCnt     (o8_KErrCnt)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [9:0] c, input logic v, input logic rd,
                           input logic ke, input logic cm, input logic [7:0] cnt);
    chk({tag, ".code"},   32'(o10_Code),        32'(c));
    chk({tag, ".vld"},    32'(o_CodeValid),     32'(v));
    chk({tag, ".rd"},     32'(o_CurrentParity), 32'(rd));
    chk({tag, ".kerr"},   32'(o_KErr),          32'(ke));
    chk({tag, ".comma"},  32'(o_Comma),         32'(cm));
    chk({tag, ".kcnt"},   32'(o8_KErrCnt),      32'(cnt));
  endtask

  task automatic send(input logic v, input logic k, input logic [7:0] d);
    @(negedge i_Clk);
    i_Valid = v;
    i_Ctrl  = k;
    i8_Data = d;
    @(posedge i_Clk);
    #1;
  endtask

  // {RD- entry, RD+ entry} for the 5b/6b data code.
  function automatic logic [11:0] m6(input logic [4:0] x);
    logic [11:0] r;
    case (x)
      5'd0:  r = {6'b100111, 6'b011000};
      5'd1:  r = {6'b011101, 6'b100010};
      5'd2:  r = {6'b101101, 6'b010010};
      5'd3:  r = {6'b110001, 6'b110001};
      5'd4:  r = {6'b110101, 6'b001010};
      5'd5:  r = {6'b101001, 6'b101001};
      5'd6:  r = {6'b011001, 6'b011001};
      5'd7:  r = {6'b111000, 6'b000111};
      5'd8:  r = {6'b111001, 6'b000110};
      5'd9:  r = {6'b100101, 6'b100101};
      5'd10: r = {6'b010101, 6'b010101};
      5'd11: r = {6'b110100, 6'b110100};
      5'd12: r = {6'b001101, 6'b001101};
      5'd13: r = {6'b101100, 6'b101100};
      5'd14: r = {6'b011100, 6'b011100};
      5'd15: r = {6'b010111, 6'b101000};
      5'd16: r = {6'b011011, 6'b100100};
      5'd17: r = {6'b100011, 6'b100011};
      5'd18: r = {6'b010011, 6'b010011};
      5'd19: r = {6'b110010, 6'b110010};
      5'd20: r = {6'b001011, 6'b001011};
      5'd21: r = {6'b101010, 6'b101010};
      5'd22: r = {6'b011010, 6'b011010};
      5'd23: r = {6'b111010, 6'b000101};
      5'd24: r = {6'b110011, 6'b001100};
      5'd25: r = {6'b100110, 6'b100110};
      5'd26: r = {6'b010110, 6'b010110};
      5'd27: r = {6'b110110, 6'b001001};
      5'd28: r = {6'b001110, 6'b001110};
      5'd29: r = {6'b101110, 6'b010001};
      5'd30: r = {6'b011110, 6'b100001};
      default: r = {6'b101011, 6'b010100};
    endcase
    return r;
  endfunction

  // {RD- entry, RD+ entry} for the 3b/4b data code (P7 for y = 7).
  function automatic logic [7:0] m4(input logic [2:0] y);
    logic [7:0] r;
    case (y)
      3'd0: r = {4'b1011, 4'b0100};
      3'd1: r = {4'b1001, 4'b1001};
      3'd2: r = {4'b0101, 4'b0101};
      3'd3: r = {4'b1100, 4'b0011};
      3'd4: r = {4'b1101, 4'b0010};
      3'd5: r = {4'b1010, 4'b1010};
      3'd6: r = {4'b0110, 4'b0110};
      default: r = {4'b1110, 4'b0001};
    endcase
    return r;
  endfunction

  // Full K28.y characters at RD-; the RD+ character is the bitwise complement.
  function automatic logic [9:0] k28_rdm(input logic [2:0] y);
    logic [9:0] r;
    case (y)
      3'd0: r = 10'b001111_0100;
      3'd1: r = 10'b001111_1001;
      3'd2: r = 10'b001111_0101;
      3'd3: r = 10'b001111_0011;
      3'd4: r = 10'b001111_0010;
      3'd5: r = 10'b001111_1010;
      3'd6: r = 10'b001111_0110;
      default: r = 10'b001111_1000;
    endcase
    return r;
  endfunction

  // Returns {kerr, comma, code}. rdm = 1 means RD- at group start.
  function automatic logic [11:0] ref_enc(input logic rdm, input logic k, input logic [7:0] d);
    logic [4:0]  x;
    logic [2:0]  y;
    logic        legal;
    logic        rd1;
    logic [11:0] s;
    logic [7:0]  f;
    logic [5:0]  six;
    logic [3:0]  four;
    logic [9:0]  code;
    logic        comma;
    x     = d[4:0];
    y     = d[7:5];
    legal = !k || (x == 5'd28) ||
            ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
    if (!legal) begin
      x = 5'd30;
      y = 3'd7;
    end
    comma = 1'b0;
    if (k && (x == 5'd28)) begin
      code  = rdm ? k28_rdm(y) : ~k28_rdm(y);
      comma = (y == 3'd1) || (y == 3'd5) || (y == 3'd7);
    end else begin
      s   = m6(x);
      six = rdm ? s[11:6] : s[5:0];
      rd1 = rdm ^ ($countones(six) != 3);
      if ((y == 3'd7) && (k || (rd1 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                          (!rd1 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))))) begin
        four = rd1 ? 4'b0111 : 4'b1000;
      end else begin
        f    = m4(y);
        four = rd1 ? f[7:4] : f[3:0];
      end
      code = {six, four};
    end
    return {!legal, comma, code};
  endfunction

  logic [7:0] legal_k [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                               8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  initial begin
    logic        m_rd;
    logic [7:0]  m_cnt;
    logic [9:0]  m_code;
    logic        m_comma;
    logic [11:0] r;
    logic        v;
    logic        k;
    logic [7:0]  d;

    i_ARst  = 1'b1;
    i_Valid = 1'b0;
    i_Ctrl  = 1'b0;
    i8_Data = 8'h00;
    repeat (2) @(posedge i_Clk);
    #1;
    check_out("reset", 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    @(negedge i_Clk);
    i_ARst = 1'b0;

    send(1'b1, 1'b1, 8'hBC); check_out("k28_5_rdm", 10'h0FA, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    send(1'b1, 1'b1, 8'hBC); check_out("k28_5_rdp", 10'h305, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
    send(1'b1, 1'b0, 8'h50); check_out("d16_2_rdm", 10'h1B5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    send(1'b1, 1'b0, 8'hC5); check_out("d5_6_rdp",  10'h296, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    send(1'b1, 1'b0, 8'hEB); check_out("d11_7_rdp", 10'h348, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    send(1'b1, 1'b0, 8'h00); check_out("d0_0_rdm",  10'h274, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    send(1'b1, 1'b0, 8'hB5); check_out("d21_5_rdm", 10'h2AA, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    send(1'b1, 1'b0, 8'hF1); check_out("d17_7_rdm", 10'h237, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    send(1'b1, 1'b1, 8'hFC); check_out("k28_7_rdp", 10'h307, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    send(1'b1, 1'b1, 8'hBC); check_out("k28_5_rdp2", 10'h305, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
    send(1'b1, 1'b1, 8'h00); check_out("illegal_k", 10'h1E8, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 1'b0, 8'h55);
      check_out("idle_hold", 10'h1E8, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    end
    send(1'b1, 1'b1, 8'hF7); check_out("k23_7_rdm", 10'h3A8, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);

    for (int i = 0; i < 300; i++) begin
      send(1'b1, 1'b1, 8'h01);
      if (i == 253) check_out("kcnt_reach", 10'h1E8, 1'b1, 1'b1, 1'b1, 1'b0, 8'd255);
    end
    check_out("kcnt_sat", 10'h1E8, 1'b1, 1'b1, 1'b1, 1'b0, 8'd255);

    send(1'b1, 1'b0, 8'h50); check_out("pre_rst", 10'h1B5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
    @(negedge i_Clk);
    i_Valid = 1'b0;
    #2;
    i_ARst = 1'b1;
    #1;
    check_out("async_rst", 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    @(negedge i_Clk);
    i_ARst = 1'b0;
    send(1'b1, 1'b0, 8'h00); check_out("post_rst", 10'h274, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

    m_rd    = 1'b1;
    m_cnt   = 8'd0;
    m_code  = 10'h274;
    m_comma = 1'b0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      k = ($urandom_range(0, 3) == 0);
      if (k) begin
        int idx;
        idx = int'($urandom_range(0, 15));
        d   = (idx < 12) ? legal_k[idx] : 8'($urandom);
      end else begin
        d = 8'($urandom);
      end
      send(v, k, d);
      if (v) begin
        r       = ref_enc(m_rd, k, d);
        m_code  = r[9:0];
        m_comma = r[10];
        m_rd    = m_rd ^ ($countones(r[9:0]) != 5);
        if (r[11] && (m_cnt != 8'hFF)) m_cnt = m_cnt + 8'd1;
        chk("rand.ones", 32'(($countones(o10_Code) >= 4) && ($countones(o10_Code) <= 6)), 32'd1);
      end
      check_out("rand", m_code, v, m_rd, v & r[11], m_comma, m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
